seq_pattern_tx: RTL and testbench

- Serial pattern transmitter that emits a programmed bit sequence as one-hot pushbutton-style strobes: P1 means '1', P2 means '0'.
- Drives the same P1/P2 interface that the team's sequence detectors consume. Used for self-test and stimulus generation on the lab board.
- Latches a pattern on a start handshake and sends it MSB-first, with a programmable idle gap between bits.
- Reports busy while sending and pulses done when finished.

---
 rtl/seq_pkg.sv | 45 ++++
 rtl/seq_gap_timer.sv | 42 ++++
 rtl/seq_pattern_tx.sv | 167 ++++++++++++++++
 tb/tb_seq_pattern_tx.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// ---------------------------------------------------------------------------
// seq_pkg
//   Shared definitions for the P1/P2 sequence family: the pattern
//   transmitter and the sequence detectors.
//
//   Contents:
//     ST_*        numeric state encodings, shared so that debug taps
//                 read the same codes on every block
//     state_t     enum built on those encodings
//     SYM_ONE     symbol value carried by a P1 strobe
//     SYM_ZERO    symbol value carried by a P2 strobe
//     GAP_W       width of the inter-bit gap counter
//     sym_strobes maps one symbol onto the {P1, P2} strobe pair
// ---------------------------------------------------------------------------
package seq_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_SEND = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_DONE = 3'd3;

    typedef enum logic [2:0] {
        S_IDLE = ST_IDLE,
        S_SEND = ST_SEND,
        S_WAIT = ST_WAIT,
        S_DONE = ST_DONE
    } state_t;

    localparam logic SYM_ONE  = 1'b1;
    localparam logic SYM_ZERO = 1'b0;

    localparam int GAP_W = 8;

    // Returns {P1, P2}. Exactly one bit is set, which keeps the two
    // strobes mutually exclusive by construction.
    function automatic logic [1:0] sym_strobes(input logic sym);
        logic [1:0] strobes;
        strobes = 2'b01;
        if (sym == SYM_ONE) begin
            strobes = 2'b10;
        end
        return strobes;
    endfunction

endpackage

// File: rtl/seq_gap_timer.sv
// ---------------------------------------------------------------------------
// seq_gap_timer
//   8-bit loadable down-counter that times the idle gap between bits.
//
//   Ports:
//     clk         system clock, rising edge
//     reset       synchronous, active-high; clears the count
//     load        load load_value (takes priority over enable)
//     load_value  gap length in cycles
//     enable      count down one step this cycle
//     expired     high during the last enabled cycle of the gap, so the
//                 owner can leave its wait state on that same edge
// ---------------------------------------------------------------------------
module seq_gap_timer
    import seq_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [GAP_W-1:0] load_value,
    input  logic             enable,
    output logic             expired
);

    logic [GAP_W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (enable && (count_reg != '0)) begin
            // Saturate at zero rather than wrapping.
            count_reg <= count_reg - GAP_W'(1);
        end
    end

    // The count holds N in the first of N wait cycles, so the final wait
    // cycle is the one where it reads 1.
    assign expired = enable && (count_reg <= GAP_W'(1));

endmodule

// File: rtl/seq_pattern_tx.sv
// ---------------------------------------------------------------------------
// seq_pattern_tx
//   Serial pattern transmitter. On a start handshake it latches a pattern
//   and sends it MSB-first as one-hot strobes: P1 for a '1', P2 for a '0'.
//   Each bit is followed by GAP idle cycles. busy is high while bits are
//   going out, and done pulses for one cycle at the end.
//
//   Parameters:
//     LEN   maximum pattern length in bits
//     GAP   idle cycles after every bit (0..255)
//     NB_W  width of nbits
//
//   Ports:
//     clk      system clock, rising edge
//     reset    synchronous, active-high; aborts a transmission without a
//              done pulse
//     start    send request, honoured only in IDLE or DONE
//     pattern  bits to send; bit nbits-1 goes first
//     nbits    number of bits to send, clamped to LEN
//     P1, P2   one-cycle strobes for the current bit
//     busy     high in SEND and WAIT
//     done     one-cycle pulse once the final bit's gap has elapsed
// ---------------------------------------------------------------------------
module seq_pattern_tx
    import seq_pkg::*;
#(
    parameter int LEN  = 8,
    parameter int GAP  = 0,
    parameter int NB_W = $clog2(LEN + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [LEN-1:0]  pattern,
    input  logic [NB_W-1:0] nbits,
    output logic            P1,
    output logic            P2,
    output logic            busy,
    output logic            done
);

    localparam logic [NB_W-1:0]  LEN_NB  = NB_W'(LEN);
    localparam logic [GAP_W-1:0] GAP_LD  = GAP_W'(GAP);
    localparam logic             HAS_GAP = (GAP > 0);

    state_t          state_reg;
    logic [LEN-1:0]  shift_reg;
    logic [NB_W-1:0] remaining_reg;
    logic            p1_reg;
    logic            p2_reg;
    logic            busy_reg;
    logic            done_reg;

    logic [NB_W-1:0] n_clamped;
    logic [LEN-1:0]  pat_aligned;
    logic [NB_W-1:0] remaining_after;
    logic            gap_load;
    logic            gap_enable;
    logic            gap_expired;

    // The pattern is left-aligned on capture, so the first bit to send
    // (bit n-1) always sits at the MSB and the register only ever shifts
    // left. When n is 0 the shift clears the whole word, which is harmless
    // because nothing is sent.
    assign n_clamped   = (nbits > LEN_NB) ? LEN_NB : nbits;
    assign pat_aligned = pattern << (LEN_NB - n_clamped);

    // The remaining-bit count never wraps below zero.
    assign remaining_after = (remaining_reg != '0) ? (remaining_reg - NB_W'(1)) : '0;

    // The timer reloads on every SEND cycle that heads into WAIT, which
    // restarts the full gap for each bit.
    assign gap_load   = HAS_GAP && (state_reg == S_SEND);
    assign gap_enable = (state_reg == S_WAIT);

    seq_gap_timer u_gap_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (gap_load),
        .load_value (GAP_LD),
        .enable     (gap_enable),
        .expired    (gap_expired)
    );

    // The outputs are registered and written on the edge that enters each
    // state. As a result the strobe for a bit appears in the same cycle in
    // which the FSM is in SEND for that bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            shift_reg     <= '0;
            remaining_reg <= '0;
            p1_reg        <= 1'b0;
            p2_reg        <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            // Strobes and done are single-cycle unless they are re-asserted below.
            p1_reg   <= 1'b0;
            p2_reg   <= 1'b0;
            done_reg <= 1'b0;

            case (state_reg)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        remaining_reg <= n_clamped;
                        if (n_clamped == '0) begin
                            state_reg <= S_DONE;
                            shift_reg <= '0;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg          <= S_SEND;
                            busy_reg           <= 1'b1;
                            {p1_reg, p2_reg}   <= sym_strobes(pat_aligned[LEN-1]);
                            shift_reg          <= pat_aligned << 1;
                        end
                    end else begin
                        state_reg <= S_IDLE;
                        busy_reg  <= 1'b0;
                    end
                end

                S_SEND: begin
                    remaining_reg <= remaining_after;
                    if (HAS_GAP) begin
                        state_reg <= S_WAIT;
                    end else if (remaining_after != '0) begin
                        // Back-to-back bits: the next strobe follows at once.
                        state_reg        <= S_SEND;
                        {p1_reg, p2_reg} <= sym_strobes(shift_reg[LEN-1]);
                        shift_reg        <= shift_reg << 1;
                    end else begin
                        state_reg <= S_DONE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end
                end

                S_WAIT: begin
                    if (gap_expired) begin
                        if (remaining_reg != '0) begin
                            state_reg        <= S_SEND;
                            {p1_reg, p2_reg} <= sym_strobes(shift_reg[LEN-1]);
                            shift_reg        <= shift_reg << 1;
                        end else begin
                            state_reg <= S_DONE;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                        end
                    end
                end

                default: begin
                    state_reg <= S_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign P1   = p1_reg;
    assign P2   = p2_reg;
    assign busy = busy_reg;
    assign done = done_reg;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// ---------------------------------------------------------------------------
// tb_seq_pattern_tx
//   Two transmitters, one with GAP=0 and one with GAP=3, share the same
//   stimulus. A timing model derived from the cycle formulas predicts
//   {P1, P2, busy, done} for every cycle after the start edge.
// ---------------------------------------------------------------------------
module tb_seq_pattern_tx;

    localparam int LEN  = 8;
    localparam int NB_W = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic [LEN-1:0]  pattern = '0;
    logic [NB_W-1:0] nbits = '0;

    logic p1_0, p2_0, busy_0, done_0;
    logic p1_3, p2_3, busy_3, done_3;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seq_pattern_tx #(.LEN(LEN), .GAP(0), .NB_W(NB_W)) dut0 (
        .clk(clk), .reset(reset), .start(start), .pattern(pattern), .nbits(nbits),
        .P1(p1_0), .P2(p2_0), .busy(busy_0), .done(done_0)
    );

    seq_pattern_tx #(.LEN(LEN), .GAP(3), .NB_W(NB_W)) dut3 (
        .clk(clk), .reset(reset), .start(start), .pattern(pattern), .nbits(nbits),
        .P1(p1_3), .P2(p2_3), .busy(busy_3), .done(done_3)
    );

    wire [3:0] obs0 = {p1_0, p2_0, busy_0, done_0};
    wire [3:0] obs3 = {p1_3, p2_3, busy_3, done_3};

    // Expected {P1,P2,busy,done} in cycle c after the start edge (edge 0).
    function automatic logic [3:0] model(input logic [7:0] pat, input int n,
                                         input int g, input int c);
        int nn, period, last, k;
        logic b;
        logic [3:0] r;
        r      = 4'b0000;
        nn     = (n > LEN) ? LEN : n;
        period = g + 1;
        last   = nn * period;
        if (nn == 0) begin
            if (c == 1) r = 4'b0001;
        end else if (c >= 1 && c <= last) begin
            r[1] = 1'b1;
            if (((c - 1) % period) == 0) begin
                k    = (c - 1) / period;
                b    = pat[nn - 1 - k];
                r[3] = b;
                r[2] = ~b;
            end
        end else if (c == last + 1) begin
            r[0] = 1'b1;
        end
        return r;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        start   = 1'b1;
        pattern = 8'hFF;
        nbits   = 4'd4;
        repeat (3) @(negedge clk);
        checks += 2;
        if (obs0 !== 4'b0000) begin failures++; $display("FAIL reset_gap0 got=%b want=0000", obs0); end
        if (obs3 !== 4'b0000) begin failures++; $display("FAIL reset_gap3 got=%b want=0000", obs3); end
        start = 1'b0;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks += 2;
        if (obs0 !== 4'b0000) begin failures++; $display("FAIL idle_gap0 got=%b want=0000", obs0); end
        if (obs3 !== 4'b0000) begin failures++; $display("FAIL idle_gap3 got=%b want=0000", obs3); end
        $display("reset: outputs checked during and after reset");
    endtask

    task automatic test_timing_1011();
        logic [3:0] e0, e3;
        do_reset();
        pattern = 8'b0000_1011;
        nbits   = 4'd4;
        start   = 1'b1;
        for (int c = 1; c <= 19; c++) begin
            @(negedge clk);
            e0 = model(8'b0000_1011, 4, 0, c);
            e3 = model(8'b0000_1011, 4, 3, c);
            checks += 2;
            if (obs0 !== e0) begin failures++; $display("FAIL t1011_gap0 c=%0d got=%b want=%b", c, obs0, e0); end
            if (obs3 !== e3) begin failures++; $display("FAIL t1011_gap3 c=%0d got=%b want=%b", c, obs3, e3); end
            if (c == 1) start = 1'b0;
        end
        $display("timing: pattern 1011 n=4 on GAP=0 and GAP=3");
    endtask

    task automatic test_random();
        logic [7:0] pat;
        int n, nn;
        logic [3:0] e0, e3;
        do_reset();
        for (int t = 0; t < 12; t++) begin
            pat     = 8'($urandom);
            n       = $urandom_range(0, 12);
            nn      = (n > LEN) ? LEN : n;
            pattern = pat;
            nbits   = NB_W'(n);
            start   = 1'b1;
            for (int c = 1; c <= nn * 4 + 3; c++) begin
                @(negedge clk);
                e0 = model(pat, n, 0, c);
                e3 = model(pat, n, 3, c);
                checks += 2;
                if (obs0 !== e0) begin failures++; $display("FAIL rand_gap0 t=%0d c=%0d got=%b want=%b", t, c, obs0, e0); end
                if (obs3 !== e3) begin failures++; $display("FAIL rand_gap3 t=%0d c=%0d got=%b want=%b", t, c, obs3, e3); end
                if (c == 1) start = 1'b0;
            end
            $display("random: txn %0d pattern=%b nbits=%0d", t, pat, n);
        end
    endtask

    task automatic test_nbits_edges();
        int s0, s3;
        logic [3:0] e0;
        do_reset();
        pattern = 8'hA5;
        nbits   = 4'd0;
        start   = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            e0 = model(8'hA5, 0, 0, c);
            checks += 2;
            if (obs0 !== e0) begin failures++; $display("FAIL n0_gap0 c=%0d got=%b want=%b", c, obs0, e0); end
            if (obs3 !== e0) begin failures++; $display("FAIL n0_gap3 c=%0d got=%b want=%b", c, obs3, e0); end
            if (c == 1) start = 1'b0;
        end
        $display("nbits: zero-length transmission");
        s0 = 0;
        s3 = 0;
        pattern = 8'h3C;
        nbits   = 4'd12;
        start   = 1'b1;
        for (int c = 1; c <= 36; c++) begin
            @(negedge clk);
            if (p1_0 || p2_0) s0++;
            if (p1_3 || p2_3) s3++;
            if (c == 1) start = 1'b0;
        end
        checks += 2;
        if (s0 !== 8) begin failures++; $display("FAIL clamp_gap0 strobes got=%0d want=8", s0); end
        if (s3 !== 8) begin failures++; $display("FAIL clamp_gap3 strobes got=%0d want=8", s3); end
        $display("nbits: 12 clamped to %0d", LEN);
    endtask

    // Overlapping 1011 Mealy detector fed from the P1/P2 strobes.
    task automatic run_loopback(input logic [7:0] pat, input int n, output logic [7:0] zmask);
        logic [3:0] hist;
        int idx;
        hist    = 4'b0000;
        idx     = 0;
        zmask   = 8'h00;
        do_reset();
        pattern = pat;
        nbits   = NB_W'(n);
        start   = 1'b1;
        for (int c = 1; c <= n + 3; c++) begin
            @(negedge clk);
            if (p1_0 || p2_0) begin
                hist = {hist[2:0], p1_0};
                idx++;
                if (idx >= 4 && hist == 4'b1011) zmask[idx - 1] = 1'b1;
            end
            if (c == 1) start = 1'b0;
        end
    endtask

    task automatic test_loopback();
        logic [7:0] zm;
        run_loopback(8'b0101_1011, 7, zm);
        checks++;
        if (zm !== 8'b0100_1000) begin failures++; $display("FAIL loop_1011011 zmask got=%b want=01001000", zm); end
        $display("loopback: 1011011 detector hits=%b", zm);
        run_loopback(8'b0000_1001, 4, zm);
        checks++;
        if (zm !== 8'b0000_0000) begin failures++; $display("FAIL loop_1001 zmask got=%b want=00000000", zm); end
        $display("loopback: 1001 detector hits=%b", zm);
    endtask

    task automatic test_busy_start();
        logic [3:0] e0, e3;
        do_reset();
        pattern = 8'b0000_1011;
        nbits   = 4'd4;
        start   = 1'b1;
        for (int c = 1; c <= 19; c++) begin
            @(negedge clk);
            e0 = model(8'b0000_1011, 4, 0, c);
            e3 = model(8'b0000_1011, 4, 3, c);
            checks += 2;
            if (obs0 !== e0) begin failures++; $display("FAIL busystart_gap0 c=%0d got=%b want=%b", c, obs0, e0); end
            if (obs3 !== e3) begin failures++; $display("FAIL busystart_gap3 c=%0d got=%b want=%b", c, obs3, e3); end
            if (c == 1) start = 1'b0;
            if (c == 2) begin start = 1'b1; pattern = 8'hFF; nbits = 4'd8; end
            if (c == 3) start = 1'b0;
        end
        $display("busy: start pulse during transmission ignored");

        do_reset();
        pattern = 8'b0000_1011;
        nbits   = 4'd4;
        start   = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            e0 = (c <= 5) ? model(8'b0000_1011, 4, 0, c) : model(8'b0000_0110, 4, 0, c - 5);
            checks++;
            if (obs0 !== e0) begin failures++; $display("FAIL held_start c=%0d got=%b want=%b", c, obs0, e0); end
            if (c == 3) pattern = 8'b0000_0110;
            if (c == 6) start = 1'b0;
        end
        $display("busy: start held through done re-latches pattern");
    endtask

    task automatic test_reset_mid();
        logic [3:0] e0, e3;
        do_reset();
        pattern = 8'b0000_1011;
        nbits   = 4'd4;
        start   = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            e0 = (c <= 3) ? model(8'b0000_1011, 4, 0, c) : 4'b0000;
            e3 = (c <= 3) ? model(8'b0000_1011, 4, 3, c) : 4'b0000;
            checks += 2;
            if (obs0 !== e0) begin failures++; $display("FAIL abort_gap0 c=%0d got=%b want=%b", c, obs0, e0); end
            if (obs3 !== e3) begin failures++; $display("FAIL abort_gap3 c=%0d got=%b want=%b", c, obs3, e3); end
            if (c == 1) start = 1'b0;
            if (c == 3) reset = 1'b1;
            if (c == 4) reset = 1'b0;
        end
        $display("reset: mid-transmission abort");
        pattern = 8'b0000_1101;
        nbits   = 4'd4;
        start   = 1'b1;
        for (int c = 1; c <= 19; c++) begin
            @(negedge clk);
            e0 = model(8'b0000_1101, 4, 0, c);
            e3 = model(8'b0000_1101, 4, 3, c);
            checks += 2;
            if (obs0 !== e0) begin failures++; $display("FAIL rerun_gap0 c=%0d got=%b want=%b", c, obs0, e0); end
            if (obs3 !== e3) begin failures++; $display("FAIL rerun_gap3 c=%0d got=%b want=%b", c, obs3, e3); end
            if (c == 1) start = 1'b0;
        end
        $display("reset: clean run after abort");
    endtask

    initial begin
        test_reset();
        test_timing_1011();
        test_random();
        test_nbits_edges();
        test_loopback();
        test_busy_start();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
